// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: drives one-hot column strobes, synchronises the rows,
// debounces press and release, and emits one key_valid pulse per physical press.
module keypad_scanner #(
   parameter int SCAN_CYCLES  = 4,
   parameter int DEBOUNCE_CNT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_CYCLES + 1);
   localparam int BW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DWELL_LAST    = DW'(SCAN_CYCLES - 1);
   localparam logic [BW-1:0] DEB_TARGET    = BW'(DEBOUNCE_CNT);
   localparam logic [BW-1:0] CNT_ONE       = BW'(1);
   localparam bit            DIRECT_ACCEPT = (DEBOUNCE_CNT == 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [3:0]    row_m, row_s;
   logic [DW-1:0] dwell, dwell_nx;
   logic [BW-1:0] deb_cnt, deb_nx;
   logic [BW-1:0] rel_cnt, rel_nx;
   logic [3:0]    cand, cand_nx;
   logic [3:0]    col_nx, code_nx;
   logic          valid_nx, held_nx;

   function automatic logic [3:0] decode(input logic [3:0] c, input logic [3:0] r);
      case ({c, r})
         8'b1000_1000: decode = 4'd1;
         8'b1000_0100: decode = 4'd4;
         8'b1000_0010: decode = 4'd7;
         8'b1000_0001: decode = 4'd14;
         8'b0100_1000: decode = 4'd2;
         8'b0100_0100: decode = 4'd5;
         8'b0100_0010: decode = 4'd8;
         8'b0100_0001: decode = 4'd0;
         8'b0010_1000: decode = 4'd3;
         8'b0010_0100: decode = 4'd6;
         8'b0010_0010: decode = 4'd9;
         8'b0010_0001: decode = 4'd15;
         8'b0001_1000: decode = 4'd10;
         8'b0001_0100: decode = 4'd11;
         8'b0001_0010: decode = 4'd12;
         8'b0001_0001: decode = 4'd13;
         default:      decode = 4'd0;
      endcase
   endfunction

   // Multi-bit rows are ghosting or multi-press and must never start a debounce.
   function automatic logic is_single(input logic [3:0] r);
      is_single = (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nx = state;
      col_nx   = col;
      dwell_nx = dwell;
      deb_nx   = deb_cnt;
      rel_nx   = rel_cnt;
      cand_nx  = cand;
      code_nx  = key_code;
      valid_nx = 1'b0;
      held_nx  = 1'b0;
      unique case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_nx = '0;
               if (is_single(row_s)) begin
                  cand_nx = row_s;
                  deb_nx  = CNT_ONE;
                  if (DIRECT_ACCEPT) begin
                     state_nx = HELD;
                     valid_nx = 1'b1;
                     held_nx  = 1'b1;
                     code_nx  = decode(col, row_s);
                     rel_nx   = '0;
                  end else begin
                     state_nx = DEBOUNCE;
                  end
               end else begin
                  col_nx = {col[0], col[3:1]};
               end
            end else begin
               dwell_nx = dwell + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (row_s == cand) begin
               deb_nx = deb_cnt + CNT_ONE;
               if (deb_cnt + CNT_ONE == DEB_TARGET) begin
                  state_nx = HELD;
                  valid_nx = 1'b1;
                  held_nx  = 1'b1;
                  code_nx  = decode(col, cand);
                  rel_nx   = '0;
               end
            end else begin
               state_nx = SCAN;
               col_nx   = {col[0], col[3:1]};
               dwell_nx = '0;
               deb_nx   = '0;
            end
         end
         HELD: begin
            held_nx = 1'b1;
            if (row_s == 4'd0) begin
               if (rel_cnt + CNT_ONE == DEB_TARGET) begin
                  state_nx = SCAN;
                  held_nx  = 1'b0;
                  col_nx   = {col[0], col[3:1]};
                  dwell_nx = '0;
                  rel_nx   = '0;
                  deb_nx   = '0;
               end else begin
                  rel_nx = rel_cnt + CNT_ONE;
               end
            end else begin
               rel_nx = '0;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state     <= SCAN;
         row_m     <= 4'd0;
         row_s     <= 4'd0;
         dwell     <= '0;
         deb_cnt   <= '0;
         rel_cnt   <= '0;
         cand      <= 4'd0;
         col       <= 4'b1000;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nx;
         row_m     <= row;
         row_s     <= row_m;
         dwell     <= dwell_nx;
         deb_cnt   <= deb_nx;
         rel_cnt   <= rel_nx;
         cand      <= cand_nx;
         col       <= col_nx;
         key_valid <= valid_nx;
         key_code  <= code_nx;
         key_held  <= held_nx;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows, and a window-based
// behavioural model predicts col/key_valid/key_code/key_held every cycle.
module tb_keypad_scanner;

   localparam int SCAN_CYCLES  = 4;
   localparam int DEBOUNCE_CNT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row, col, key_code;
   logic       key_valid, key_held;

   keypad_scanner #(.SCAN_CYCLES(SCAN_CYCLES), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // key_map[column index][row index], index 0 = left column / top row
   int key_map [4][4] = '{'{1, 4, 7, 14}, '{2, 5, 8, 0}, '{3, 6, 9, 15}, '{10, 11, 12, 13}};
   logic [15:0] pressed;

   // Physical matrix: a pressed key pulls its row high only while its column is strobed.
   always_comb begin
      row = 4'b0000;
      for (int c = 0; c < 4; c++)
         if (col[3-c] === 1'b1)
            for (int r = 0; r < 4; r++)
               if (pressed[key_map[c][r]]) row[3-r] = 1'b1;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_SCAN, M_DEB, M_HELD} mmode_t;
   mmode_t     m_mode;
   int         m_col_idx, m_t;
   logic [3:0] m_cand, m_code, m_pipe0, m_pipe1;
   logic       m_valid;
   logic [3:0] m_win[$];
   int         mdl_codes[$];
   bit         cmp_en = 1'b0;

   function automatic int row_idx(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (r[3-i]) return i;
      return 0;
   endfunction

   always @(posedge clk) begin
      logic [3:0] rs;
      bit all_zero;
      rs = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = row;
      m_valid = 1'b0;
      if (rst) begin
         m_pipe0 = 4'd0; m_pipe1 = 4'd0;
         m_mode = M_SCAN; m_col_idx = 0; m_t = 0; m_code = 4'd0; m_cand = 4'd0;
         m_win.delete();
      end else begin
         case (m_mode)
            M_SCAN: begin
               if (m_t == SCAN_CYCLES - 1) begin
                  m_t = 0;
                  if ($countones(rs) == 1) begin
                     m_cand = rs; m_win.delete(); m_win.push_back(rs); m_mode = M_DEB;
                  end else m_col_idx = (m_col_idx + 1) % 4;
               end else m_t++;
            end
            M_DEB: begin
               if (rs != m_cand) begin
                  m_mode = M_SCAN; m_col_idx = (m_col_idx + 1) % 4; m_t = 0;
               end else m_win.push_back(rs);
            end
            default: begin
               m_win.push_back(rs);
               if (m_win.size() > DEBOUNCE_CNT) void'(m_win.pop_front());
               all_zero = 1'b1;
               foreach (m_win[i]) if (m_win[i] != 4'd0) all_zero = 1'b0;
               if (m_win.size() == DEBOUNCE_CNT && all_zero) begin
                  m_mode = M_SCAN; m_col_idx = (m_col_idx + 1) % 4; m_t = 0;
               end
            end
         endcase
         // A run of DEBOUNCE_CNT identical samples starting at the column's last dwell clock is a press.
         if (m_mode == M_DEB && m_win.size() >= DEBOUNCE_CNT) begin
            m_mode  = M_HELD;
            m_valid = 1'b1;
            m_code  = 4'(key_map[m_col_idx][row_idx(m_cand)]);
            mdl_codes.push_back(int'(m_code));
            m_win.delete();
         end
      end
   end

   always @(negedge clk) if (cmp_en) begin
      check("col", col, 4'b1000 >> m_col_idx);
      check("key_valid", key_valid, m_valid);
      check("key_held", key_held, m_mode == M_HELD);
      check("key_code", key_code, m_code);
   end

   // ---------------- event monitor ----------------
   int         dut_codes[$];
   int         exp_codes[$];
   int         pulse_cnt = 0, held_cycles = 0, held_off_col = 0;
   logic [3:0] col_at_release = 4'hx;
   bit         prev_held = 1'b0;

   always @(negedge clk) if (cmp_en) begin
      if (key_valid === 1'b1) begin
         dut_codes.push_back(int'(key_code));
         pulse_cnt++;
      end
      if (key_held === 1'b1) begin
         held_cycles++;
         if (col !== 4'b0100) held_off_col++;
      end
      if (prev_held && key_held === 1'b0) col_at_release = col;
      prev_held = (key_held === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_events(input string name);
      check({name, " dut count"}, dut_codes.size(), exp_codes.size());
      check({name, " model count"}, mdl_codes.size(), exp_codes.size());
      for (int i = 0; i < exp_codes.size(); i++) begin
         check({name, " dut code"}, (i < dut_codes.size()) ? dut_codes[i] : 32'hFF, exp_codes[i]);
         check({name, " model code"}, (i < mdl_codes.size()) ? mdl_codes[i] : 32'hFF, exp_codes[i]);
      end
      dut_codes.delete(); mdl_codes.delete(); exp_codes.delete();
   endtask

   task automatic press(input int k, input int hold, input int rel);
      pressed[k] = 1'b1;
      tick(hold);
      pressed[k] = 1'b0;
      tick(rel);
   endtask

   task automatic wait_mode(input mmode_t m, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick(1);
         if (m_mode == m) found = 1'b1;
      end
      check({name, " reached"}, found, 1'b1);
   endtask

   task automatic pulse_reset(input string name);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      pressed = '0;
      @(negedge clk);
      check({name, " col"}, col, 4'b1000);
      check({name, " key_held"}, key_held, 1'b0);
      check({name, " key_valid"}, key_valid, 1'b0);
      tick(1);
   endtask

   initial begin
      int p0;
      bit found;
      rst = 1'b1;
      pressed = '0;
      @(posedge clk);
      #1 cmp_en = 1'b1;
      tick(1);
      rst = 1'b0;

      // Idle scan: 4 clocks per column, rotating left to right.
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (j == 0) begin
            check("reset key_valid", key_valid, 1'b0);
            check("reset key_held", key_held, 1'b0);
            check("reset key_code", key_code, 4'd0);
         end
         check("idle col", col, 4'b1000 >> ((j / 4) % 4));
      end
      check("idle pulses", pulse_cnt, 0);
      tick(1);

      // Press sequence 1, 8, 6, 5.
      press(1, 30, 30); press(8, 30, 30); press(6, 30, 30); press(5, 30, 30);
      exp_codes = '{1, 8, 6, 5};
      check_events("sequence");

      // Bounce on key 8 while its column is strobed.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (col === 4'b0100) found = 1'b1;
      end
      check("bounce col reached", found, 1'b1);
      p0 = pulse_cnt;
      pressed[8] = 1'b1; tick(1);
      pressed[8] = 1'b0; tick(1);
      pressed[8] = 1'b1; tick(1);
      pressed[8] = 1'b0; tick(2);
      check("bounce no pulse", pulse_cnt - p0, 0);
      press(8, 40, 30);
      exp_codes = '{8};
      check_events("bounce");

      // Long hold of key 0: one event, column frozen, resume at next column.
      held_cycles = 0; held_off_col = 0; col_at_release = 4'hx;
      press(0, 100, 30);
      exp_codes = '{0};
      check_events("hold0");
      check("hold0 held length in 80..105", (held_cycles >= 80 && held_cycles <= 105), 1'b1);
      check("hold0 col frozen", held_off_col, 0);
      check("hold0 col after release", col_at_release, 4'b0010);

      // Ghost 1100 in the left column is ignored; then # and D.
      pressed[1] = 1'b1; pressed[4] = 1'b1;
      tick(40);
      pressed = '0;
      tick(10);
      check_events("ghost");
      press(15, 30, 30); press(13, 30, 30);
      exp_codes = '{15, 13};
      check_events("hash_d");

      // Reset in the middle of debounce, then in the middle of a hold.
      pressed[5] = 1'b1;
      wait_mode(M_DEB, "mid-debounce");
      pulse_reset("rst debounce");
      tick(20);
      check_events("rst debounce");
      pressed[5] = 1'b1;
      wait_mode(M_HELD, "mid-held");
      tick(5);
      pulse_reset("rst held");
      tick(20);
      exp_codes = '{5};
      check_events("rst held");

      // Fresh press after reset recovery.
      press(9, 30, 30);
      exp_codes = '{9};
      check_events("fresh");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
